// File: rtl/mem_pkg.sv
// Shared types and limits for the data-memory responder.
package mem_pkg;
    typedef logic [7:0] byte_t;
    typedef byte_t [0:3] word_lanes_t;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam int MAX_LATENCY = 255;
endpackage

// File: rtl/mem_array.sv
// Word storage with write-through echo and a registered, holding read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-3:0] addr,
    input  word_lanes_t           wdata,
    output word_lanes_t           rdata
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    word_lanes_t mem_q [DEPTH];
    word_lanes_t rdata_d;
    word_lanes_t rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[addr] <= wdata;
        end
    end

    // The output register only moves on an access, so it doubles as the held response.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = we ? wdata : mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency single-word memory responder for the core's data port.
// Define MEM_ALIGN_CHECK_EN to flag misaligned requests with rsp_err.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  word_lanes_t req_wdata,
    output logic        rsp_valid,
    output word_lanes_t rsp_rdata,
    output logic        rsp_err
);
    localparam int CNT_W = $clog2(MAX_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-3:0] idx_q, idx_d;
    logic                  write_q, write_d;
    word_lanes_t           wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  access;
    logic                  mem_en;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic err_q, err_d;
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_WIDTH];
`else
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH], req_addr[1:0]};
`endif

    assign access = (state_q == BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        valid_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = misalign_q;
        err_d      = access ? misalign_q : err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    idx_d   = req_addr[ADDR_WIDTH-1:2];
                    write_d = req_write;
                    wdata_d = req_wdata;
                    ready_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_d = (req_addr[1:0] != 2'b00);
`endif
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
            err_q      <= err_d;
`endif
        end
    end

    // A misaligned access neither writes nor disturbs the held read data.
`ifdef MEM_ALIGN_CHECK_EN
    assign mem_en  = access && !misalign_q;
    assign rsp_err = err_q;
`else
    assign mem_en  = access;
    assign rsp_err = 1'b0;
`endif

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem_array (
        .clk  (clk),
        .rst_b(rst_b),
        .en   (mem_en),
        .we   (write_q),
        .addr (idx_q),
        .wdata(wdata_q),
        .rdata(rsp_rdata)
    );

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
endmodule
